ahb_master_arbiter: RTL
=======================

# ahb_master_arbiter

Two-master AHB-Lite arbiter that shares the core's single external AHB-Lite master port between the instruction-cache fill engine (master 0) and the data-side uncached/peripheral port (master 1). Each master sees a private AHB-Lite master interface. The arbiter multiplexes address and control by the address-phase owner and routes HWDATA and the slave response by the data-phase owner. It stalls the losing master through its private HREADY, and never reorders, drops or splits transfers.

## Interface
- PRIORITY_MODE, 0: 0 = round-robin, 1 = fixed priority to master 0.
- PARK_MASTER, 0: owner after reset and when no master requests.
- HCLK  in  1  clock
- HRESETn  in  1  asynchronous active-low reset
- mX_HADDR / mX_HTRANS / mX_HWRITE / mX_HSIZE / mX_HBURST / mX_HPROT  in  32/2/1/3/3/4  master X address and control (X = 0, 1)
- mX_HWDATA  in  32  master X write data
- mX_HRDATA  out  32  broadcast copy of HRDATA
- mX_HREADY  out  1  master X ready
- mX_HRESP  out  1  master X response
- HADDR / HTRANS / HWRITE / HSIZE / HBURST / HPROT / HWDATA  out  32/2/1/3/3/4/32  shared bus
- HRDATA  in  32, HREADY  in  1, HRESP  in  1  shared bus response
- owner  out  1  current address-phase owner

## Operation
- **Registers**, all reset asynchronously:
  - owner_q = PARK_MASTER
  - last_q = 1
  - lock_q = 0
  - hold_q = 0
  - dp_valid = 0
  - dp_owner = 0
- **grant** (combinational) selects which master's address/control drive HADDR..HPROT.
- **Effective lock:** locked = lock_q and owner_q presents SEQ or BUSY.
- **Arbitration allowed** only when all of the following hold:
  - not locked;
  - hold_q = 0;
  - owner_q presents IDLE, or owner_q has no data phase in flight (dp_valid = 0 or dp_owner ≠ owner_q).
- **If arbitration is not allowed:** grant = owner_q.
- **If arbitration is allowed:** the requesters are the masters presenting NONSEQ.
  - No requesters: grant = PARK_MASTER.
  - One requester: grant goes to it.
  - Both requesting, PRIORITY_MODE = 1: master 0.
  - Both requesting, PRIORITY_MODE = 0: the master that is not last_q.
- **Every edge:**
  - owner_q ← grant.
  - hold_q ← (HREADY = 0 and bus HTRANS ≠ IDLE).
  - last_q ← grant when the bus HTRANS is NONSEQ and HREADY = 1.
- **Lock:**
  - lock_q ← 1 on an accepted NONSEQ (HREADY = 1) with HBURST ≠ SINGLE.
  - lock_q ← 0 on an accepted IDLE or NONSEQ-SINGLE from the owner.
  - An aborted burst (owner goes IDLE after an ERROR) therefore releases the lock.
- **Data phase:** on every edge with HREADY = 1:
  - dp_valid ← HTRANS[1];
  - dp_owner ← grant.
- **Response routing:**
  - HWDATA = m[dp_owner]_HWDATA.
  - mX_HRESP = HRESP when dp_valid and dp_owner = X, else 0.
- **mX_HREADY**, first matching rule wins:
  - HREADY, if dp_valid and dp_owner = X;
  - HREADY, if grant = X;
  - 1, if mX_HTRANS = IDLE;
  - 0, otherwise (stall).
- **Rule this guarantees:** a master holding an in-flight data phase is never denied grant while it presents a new transfer. Starvation is possible only if the owner issues back-to-back transfers with no IDLE. The icache fill engine inserts IDLE between line fills.

## Timing
- Grant is combinational from registered state plus the masters' HTRANS. No cycle is lost on a switch: a waiting NONSEQ reaches HADDR in the same cycle arbitration is allowed.
- Address and control stay stable while HREADY is low (hold_q).
- The owner changes only at cycle boundaries where HREADY = 1 or the bus is IDLE.
- Read data reaches the data-phase owner with zero added latency. mX_HRDATA is a wire.
- Reset mid-transfer: all registers return to their reset values immediately. Outputs then follow PARK_MASTER's inputs.
- Masters must drive IDLE during reset.

## Test plan
- **Reset:** assert HRESETn low with both masters IDLE → owner = 0, HTRANS = IDLE, m0_HREADY = m1_HREADY = 1.
- **Single read:** m1 NONSEQ read at 0x2000_0000 while m0 is IDLE → same cycle HADDR = 0x2000_0000 and owner = 1; next cycle HRDATA = 0xDEADBEEF with HREADY = 1 → m1 receives 0xDEADBEEF, m1_HREADY = 1.
- **Round-robin:** simultaneous NONSEQ from both masters with last_q = 0 → m1 granted, m0_HREADY = 0 for that cycle; after m1 goes IDLE, m0's NONSEQ appears on HADDR.
- **Burst lock:** m0 WRAP4 at 0x100 (beats 0x100, 0x104, 0x108, 0x10C) while m1 requests from beat 1 → m1_HREADY = 0 for all four beats; m1 is granted in the cycle m0 presents IDLE.
- **Wait states:** HREADY = 0 for 3 cycles during m0's NONSEQ address phase while m1 requests → HADDR and owner unchanged across all 3 cycles; m1 is stalled.
- **Error release:** HRESP = 1 on m0 INCR4 beat 2, after which m0 issues IDLE → lock released, m1 granted the next cycle, m1_HRESP stays 0 throughout, m0_HRESP = 1 for both ERROR cycles.

Source files
------------

// File: rtl/ahb_master_arbiter_if.sv
// Bundle of the two private AHB-Lite master ports and the shared AHB-Lite bus
// seen by the two-master arbiter.
interface ahb_master_arbiter_if;
    // Master 0 (icache fill engine)
    logic [31:0] m0_HADDR;
    logic [1:0]  m0_HTRANS;
    logic        m0_HWRITE;
    logic [2:0]  m0_HSIZE;
    logic [2:0]  m0_HBURST;
    logic [3:0]  m0_HPROT;
    logic [31:0] m0_HWDATA;
    logic [31:0] m0_HRDATA;
    logic        m0_HREADY;
    logic        m0_HRESP;

    // Master 1 (data-side uncached / peripheral port)
    logic [31:0] m1_HADDR;
    logic [1:0]  m1_HTRANS;
    logic        m1_HWRITE;
    logic [2:0]  m1_HSIZE;
    logic [2:0]  m1_HBURST;
    logic [3:0]  m1_HPROT;
    logic [31:0] m1_HWDATA;
    logic [31:0] m1_HRDATA;
    logic        m1_HREADY;
    logic        m1_HRESP;

    // Shared bus
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    // Arbiter view: drives the shared bus and the private responses.
    modport master (
        input  m0_HADDR, m0_HTRANS, m0_HWRITE, m0_HSIZE, m0_HBURST, m0_HPROT, m0_HWDATA,
        output m0_HRDATA, m0_HREADY, m0_HRESP,
        input  m1_HADDR, m1_HTRANS, m1_HWRITE, m1_HSIZE, m1_HBURST, m1_HPROT, m1_HWDATA,
        output m1_HRDATA, m1_HREADY, m1_HRESP,
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
        input  HRDATA, HREADY, HRESP
    );

    // Environment view: the two masters plus the downstream slave.
    modport slave (
        output m0_HADDR, m0_HTRANS, m0_HWRITE, m0_HSIZE, m0_HBURST, m0_HPROT, m0_HWDATA,
        input  m0_HRDATA, m0_HREADY, m0_HRESP,
        output m1_HADDR, m1_HTRANS, m1_HWRITE, m1_HSIZE, m1_HBURST, m1_HPROT, m1_HWDATA,
        input  m1_HRDATA, m1_HREADY, m1_HRESP,
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/ahb_master_arbiter.sv
// Two-master AHB-Lite arbiter: muxes address/control by the address-phase owner,
// routes write data and responses by the data-phase owner, stalls the loser via HREADY.
module ahb_master_arbiter #(
    parameter bit PRIORITY_MODE = 1'b0,
    parameter bit PARK_MASTER   = 1'b0
) (
    input  logic                        HCLK,
    input  logic                        HRESETn,
    ahb_master_arbiter_if.master        bus,
    output logic                        owner
);

    localparam logic [1:0] TrIdle       = 2'b00;
    localparam logic [1:0] TrBusy       = 2'b01;
    localparam logic [1:0] TrNonseq     = 2'b10;
    localparam logic [1:0] TrSeq        = 2'b11;
    localparam logic [2:0] BurstSingle  = 3'b000;

    logic owner_q;
    logic last_q;
    logic lock_q;
    logic hold_q;
    logic dp_valid_q;
    logic dp_owner_q;

    logic       grant;
    logic [1:0] owner_trans;
    logic       locked;
    logic       owner_dp;
    logic       arb_ok;
    logic       req0;
    logic       req1;

    // Arbitration
    always_comb begin
        owner_trans = owner_q ? bus.m1_HTRANS : bus.m0_HTRANS;
        locked      = lock_q && ((owner_trans == TrSeq) || (owner_trans == TrBusy));
        owner_dp    = dp_valid_q && (dp_owner_q == owner_q);
        arb_ok      = !locked && !hold_q && ((owner_trans == TrIdle) || !owner_dp);
        req0        = (bus.m0_HTRANS == TrNonseq);
        req1        = (bus.m1_HTRANS == TrNonseq);

        grant = owner_q;
        if (arb_ok) begin
            unique case ({req1, req0})
                2'b00:   grant = PARK_MASTER;
                2'b01:   grant = 1'b0;
                2'b10:   grant = 1'b1;
                default: grant = PRIORITY_MODE ? 1'b0 : ~last_q;
            endcase
        end
    end

    // Address and control follow the grant with no added cycle.
    always_comb begin
        if (grant) begin
            bus.HADDR  = bus.m1_HADDR;
            bus.HTRANS = bus.m1_HTRANS;
            bus.HWRITE = bus.m1_HWRITE;
            bus.HSIZE  = bus.m1_HSIZE;
            bus.HBURST = bus.m1_HBURST;
            bus.HPROT  = bus.m1_HPROT;
        end else begin
            bus.HADDR  = bus.m0_HADDR;
            bus.HTRANS = bus.m0_HTRANS;
            bus.HWRITE = bus.m0_HWRITE;
            bus.HSIZE  = bus.m0_HSIZE;
            bus.HBURST = bus.m0_HBURST;
            bus.HPROT  = bus.m0_HPROT;
        end
    end

    // Data-phase routing and per-master ready/response.
    always_comb begin
        bus.HWDATA    = dp_owner_q ? bus.m1_HWDATA : bus.m0_HWDATA;
        bus.m0_HRDATA = bus.HRDATA;
        bus.m1_HRDATA = bus.HRDATA;
        bus.m0_HRESP  = (dp_valid_q && !dp_owner_q) ? bus.HRESP : 1'b0;
        bus.m1_HRESP  = (dp_valid_q &&  dp_owner_q) ? bus.HRESP : 1'b0;

        if (dp_valid_q && !dp_owner_q) begin
            bus.m0_HREADY = bus.HREADY;
        end else if (!grant) begin
            bus.m0_HREADY = bus.HREADY;
        end else begin
            bus.m0_HREADY = (bus.m0_HTRANS == TrIdle);
        end

        if (dp_valid_q && dp_owner_q) begin
            bus.m1_HREADY = bus.HREADY;
        end else if (grant) begin
            bus.m1_HREADY = bus.HREADY;
        end else begin
            bus.m1_HREADY = (bus.m1_HTRANS == TrIdle);
        end

        owner = grant;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            owner_q    <= PARK_MASTER;
            last_q     <= 1'b1;
            lock_q     <= 1'b0;
            hold_q     <= 1'b0;
            dp_valid_q <= 1'b0;
            dp_owner_q <= 1'b0;
        end else begin
            owner_q <= grant;
            // A stretched address phase freezes ownership until it completes.
            hold_q  <= !bus.HREADY && (bus.HTRANS != TrIdle);
            if (bus.HREADY && (bus.HTRANS == TrNonseq)) begin
                last_q <= grant;
            end
            if (bus.HREADY) begin
                if ((bus.HTRANS == TrNonseq) && (bus.HBURST != BurstSingle)) begin
                    lock_q <= 1'b1;
                end else if ((bus.HTRANS == TrIdle) || (bus.HTRANS == TrNonseq)) begin
                    lock_q <= 1'b0;
                end
                dp_valid_q <= bus.HTRANS[1];
                dp_owner_q <= grant;
            end
        end
    end

endmodule
